// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, the default halt opcode
// and the fetch FSM state encoding.
package cpu_pkg;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned INSTR_W  = OPCODE_W + IMM_W;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;
endpackage

// File: rtl/instr_mem.sv
// Instruction storage: DEPTH x INSTR_W words, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (combinational read port).
// Contents are not reset.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: streams words from instr_mem to the decoder with a
// valid/ready handshake, stops after presenting a halt-opcode word, and accepts
// jump redirects while running.
// Ports: clk, rst_n (async active-low), start, prog_we/prog_addr/prog_data
// (program load, only honoured in IDLE/HALT), instr_out/instr_valid/instr_ready
// (decoder handshake), jump_en/jump_target (redirect), pc_out (next fetch
// address), halted (high in HALT).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          MEM_DEPTH   = 256,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         prog_we,
  input  logic [7:0]   prog_addr,
  input  logic [7:0]   prog_data,
  output logic [7:0]   instr_out,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jump_en,
  input  logic [7:0]   jump_target,
  output logic [7:0]   pc_out,
  output logic         halted
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  fetch_state_t       state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic               loadable;

  assign loadable = (state_q == ST_IDLE) || (state_q == ST_HALT);

  instr_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we && loadable),
    .waddr (prog_addr[AW-1:0]),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (jump_en) begin
          pc_d    = jump_target[AW-1:0];
          valid_d = 1'b0;
        end else if (!valid_q || instr_ready) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          pc_d    = pc_q + AW'(1);
          if (mem_rdata[INSTR_W-1 -: OPCODE_W] == HALT_OPCODE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A redirect here discards the presented halt word and resumes fetching.
        if (jump_en) begin
          pc_d    = jump_target[AW-1:0];
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = 8'(pc_q);
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump_en;
  logic [7:0] jump_target;
  logic [7:0] pc_out;
  logic       halted;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int used;

  fetch_unit #(
    .MEM_DEPTH   (256),
    .HALT_OPCODE (4'hF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Compare every handshaken word against the scoreboard until it empties.
  task automatic drain(input int max_cycles, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      if (instr_valid && instr_ready) check("sb_instr", instr_out, exp_q.pop_front());
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("sb_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    instr_ready = 1'b0; jump_en = 1'b0; jump_target = '0;
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_instr", instr_out, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    load(8'h00, 8'h11); load(8'h01, 8'h22); load(8'h02, 8'hF0);
    load(8'h10, 8'h35); load(8'h11, 8'hF0);

    // Straight-line program, always ready
    instr_ready = 1'b1;
    do_start();
    check("start_bubble", instr_valid, 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'hF0);
    drain(20, used);
    check("stream_cycles", used, 4);
    check("halt_flag", halted, 1);
    check("halt_pc", pc_out, 3);
    check("halt_valid", instr_valid, 0);

    // Jump ignored while halted
    jump_en = 1'b1; jump_target = 8'h10;
    tick();
    jump_en = 1'b0;
    check("jump_in_halt_pc", pc_out, 3);
    check("jump_in_halt_halted", halted, 1);

    // Backpressure: first word held for 3 cycles
    instr_ready = 1'b0;
    do_start();
    check("bp_bubble", instr_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_instr", instr_out, 8'h11);
      check("bp_hold_valid", instr_valid, 1);
      check("bp_hold_pc", pc_out, 1);
      tick();
    end
    instr_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'hF0);
    drain(20, used);
    check("bp_halted", halted, 1);
    check("bp_pc", pc_out, 3);

    // Jump during RUN
    do_start();
    exp_q.push_back(8'h11);
    drain(10, used);
    check("pre_jump_instr", instr_out, 8'h22);
    jump_en = 1'b1; jump_target = 8'h10;
    tick();
    jump_en = 1'b0;
    check("jump_bubble_valid", instr_valid, 0);
    check("jump_bubble_pc", pc_out, 8'h10);
    tick();
    check("jump_instr", instr_out, 8'h35);
    check("jump_valid", instr_valid, 1);
    check("jump_pc", pc_out, 8'h11);
    tick();
    check("drain_instr", instr_out, 8'hF0);
    check("drain_pc", pc_out, 8'h12);

    // Jump during DRAIN cancels the halt
    instr_ready = 1'b0;
    jump_en = 1'b1; jump_target = 8'h10;
    tick();
    jump_en = 1'b0;
    check("djump_halted", halted, 0);
    check("djump_valid", instr_valid, 0);
    check("djump_pc", pc_out, 8'h10);
    tick();
    check("djump_instr", instr_out, 8'h35);
    check("djump_halted2", halted, 0);
    instr_ready = 1'b1;
    exp_q.push_back(8'h35); exp_q.push_back(8'hF0);
    drain(10, used);
    check("djump_final_halted", halted, 1);

    // PC wrap from 0xFF to 0
    load(8'hFF, 8'h01); load(8'h00, 8'h02); load(8'h01, 8'hF0);
    do_start();
    jump_en = 1'b1; jump_target = 8'hFF;
    tick();
    jump_en = 1'b0;
    check("wrap_pc_ff", pc_out, 8'hFF);
    tick();
    check("wrap_instr0", instr_out, 8'h01);
    check("wrap_pc0", pc_out, 8'h00);
    tick();
    check("wrap_instr1", instr_out, 8'h02);
    check("wrap_pc1", pc_out, 8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'hF0);
    drain(10, used);
    check("wrap_halted", halted, 1);

    // Write and start in the same cycle; writes ignored in RUN; async reset
    instr_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h00; prog_data = 8'h11; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    tick();
    check("same_cycle_instr", instr_out, 8'h11);
    check("same_cycle_valid", instr_valid, 1);
    load(8'h01, 8'h77);
    check("run_write_hold", instr_out, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc_out, 0);
    check("arst_instr", instr_out, 0);
    check("arst_halted", halted, 0);
    tick();
    rst_n = 1'b1;
    tick();
    instr_ready = 1'b1;
    do_start();
    exp_q.push_back(8'h11); exp_q.push_back(8'hF0);
    drain(10, used);
    check("post_rst_halted", halted, 1);
    check("post_rst_pc", pc_out, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
